// File: rtl/micro_pc_sequencer.sv
// Micro-program counter and next-address sequencer for the microcoded RV32I core.
// Holds the uPC that addresses the microcode ROM, resolves the ROM's next-address
// select field (including opcode dispatch), and owns the sticky trap state and the
// retired-instruction counter.
//
// state (upc_q)        | meaning
// RESET_UADDR, +1      | reset micro-sequence; edges leaving it never retire
// FETCH_UADDR          | instruction fetch micro-step
// ILLEGAL_UADDR        | unknown-instruction trap, frozen until reset
// MISAL_UADDR          | misaligned-address trap, frozen until reset
// others               | execute micro-steps of the dispatched instruction

module micro_pc_sequencer #(
  parameter int unsigned UPC_W         = 5,
  parameter int unsigned RESET_UADDR   = 2,
  parameter int unsigned FETCH_UADDR   = 4,
  parameter int unsigned ILLEGAL_UADDR = 0,
  parameter int unsigned MISAL_UADDR   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall_i,
  input  logic [2:0]       upc_sel_i,
  input  logic [31:0]      ir_i,
  input  logic             misaligned_i,
  output logic [UPC_W-1:0] upc_o,
  output logic             ustep_o,
  output logic             trap_o,
  output logic [1:0]       trap_cause_o,
  output logic [31:0]      instret_o
);

  // Select field encodings, shared with the microcode ROM.
  localparam logic [2:0] SEL_NOP            = 3'd0;
  localparam logic [2:0] SEL_INC            = 3'd1;
  localparam logic [2:0] SEL_JUMP           = 3'd2;
  localparam logic [2:0] SEL_FETCH          = 3'd3;
  localparam logic [2:0] SEL_FETCH_OR_MISAL = 3'd4;
  localparam logic [2:0] SEL_INC_OR_MISAL   = 3'd5;

  localparam logic [UPC_W-1:0] RESET_A      = UPC_W'(RESET_UADDR);
  localparam logic [UPC_W-1:0] RESET_NEXT_A = UPC_W'(RESET_UADDR + 1);
  localparam logic [UPC_W-1:0] FETCH_A      = UPC_W'(FETCH_UADDR);
  localparam logic [UPC_W-1:0] ILLEGAL_A    = UPC_W'(ILLEGAL_UADDR);
  localparam logic [UPC_W-1:0] MISAL_A      = UPC_W'(MISAL_UADDR);

  // Entry points of the per-instruction-class micro-routines.
  localparam logic [UPC_W-1:0] LUI_A    = UPC_W'(6);
  localparam logic [UPC_W-1:0] AUIPC_A  = UPC_W'(7);
  localparam logic [UPC_W-1:0] JAL_A    = UPC_W'(8);
  localparam logic [UPC_W-1:0] JALR_A   = UPC_W'(9);
  localparam logic [UPC_W-1:0] BRANCH_A = UPC_W'(10);
  localparam logic [UPC_W-1:0] LOAD_A   = UPC_W'(12);
  localparam logic [UPC_W-1:0] STORE_A  = UPC_W'(14);
  localparam logic [UPC_W-1:0] OPIMM_A  = UPC_W'(16);
  localparam logic [UPC_W-1:0] OP_A     = UPC_W'(17);

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_MISAL   = 2'b10;

  logic [UPC_W-1:0] upc_q, upc_d;
  logic             trap_q, trap_d;
  logic [1:0]       cause_q, cause_d;
  logic [31:0]      instret_q, instret_d;

  logic [UPC_W-1:0] dispatch_uaddr;
  logic [UPC_W-1:0] next_upc;
  logic [UPC_W-1:0] upc_inc;
  logic             commit;
  logic             in_reset_seq;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       unused_ir;

  assign opcode    = ir_i[6:0];
  assign funct3    = ir_i[14:12];
  assign funct7    = ir_i[31:25];
  assign unused_ir = ^{ir_i[24:15], ir_i[11:7]};

  assign commit       = !stall_i && !trap_q;
  assign upc_inc      = upc_q + UPC_W'(1);
  assign in_reset_seq = (upc_q == RESET_A) || (upc_q == RESET_NEXT_A);

  // Opcode dispatch: map the instruction to its micro-routine, or to the illegal trap.
  always_comb begin
    dispatch_uaddr = ILLEGAL_A;
    unique case (opcode)
      7'b0110111: dispatch_uaddr = LUI_A;
      7'b0010111: dispatch_uaddr = AUIPC_A;
      7'b1101111: dispatch_uaddr = JAL_A;
      7'b1100111: if (funct3 == 3'b000) dispatch_uaddr = JALR_A;
      7'b1100011: if (funct3 != 3'b010 && funct3 != 3'b011) dispatch_uaddr = BRANCH_A;
      7'b0000011: if (funct3 != 3'b011 && funct3 != 3'b110 && funct3 != 3'b111)
                    dispatch_uaddr = LOAD_A;
      7'b0100011: if (funct3 <= 3'b010) dispatch_uaddr = STORE_A;
      7'b0010011: begin
        if (funct3 == 3'b001) begin
          if (funct7 == 7'b0000000) dispatch_uaddr = OPIMM_A;
        end else if (funct3 == 3'b101) begin
          if (funct7 == 7'b0000000 || funct7 == 7'b0100000) dispatch_uaddr = OPIMM_A;
        end else begin
          dispatch_uaddr = OPIMM_A;
        end
      end
      7'b0110011: begin
        if (funct7 == 7'b0000000) dispatch_uaddr = OP_A;
        else if (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101))
          dispatch_uaddr = OP_A;
      end
      default: dispatch_uaddr = ILLEGAL_A;
    endcase
  end

  // Next-address select from the ROM's micro-PC select field.
  always_comb begin
    next_upc = ILLEGAL_A;
    unique case (upc_sel_i)
      SEL_NOP:            next_upc = upc_q;
      SEL_INC:            next_upc = upc_inc;
      SEL_JUMP:           next_upc = dispatch_uaddr;
      SEL_FETCH:          next_upc = FETCH_A;
      SEL_FETCH_OR_MISAL: next_upc = misaligned_i ? MISAL_A : FETCH_A;
      SEL_INC_OR_MISAL:   next_upc = misaligned_i ? MISAL_A : upc_inc;
      default:            next_upc = ILLEGAL_A;
    endcase
  end

  // Commit the micro-step: advance uPC, latch trap entry, count retirements.
  always_comb begin
    upc_d     = upc_q;
    trap_d    = trap_q;
    cause_d   = cause_q;
    instret_d = instret_q;
    if (commit) begin
      upc_d = next_upc;
      if (next_upc == ILLEGAL_A) begin
        trap_d  = 1'b1;
        cause_d = CAUSE_ILLEGAL;
      end else if (next_upc == MISAL_A) begin
        trap_d  = 1'b1;
        cause_d = CAUSE_MISAL;
      end
      // Reaching FETCH from the reset sequence is not the end of an instruction.
      if (next_upc == FETCH_A && !in_reset_seq) instret_d = instret_q + 32'd1;
    end
  end

  // Sequencer state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      upc_q     <= RESET_A;
      trap_q    <= 1'b0;
      cause_q   <= CAUSE_NONE;
      instret_q <= 32'd0;
    end else begin
      upc_q     <= upc_d;
      trap_q    <= trap_d;
      cause_q   <= cause_d;
      instret_q <= instret_d;
    end
  end

  assign upc_o        = upc_q;
  assign ustep_o      = commit;
  assign trap_o       = trap_q;
  assign trap_cause_o = cause_q;
  assign instret_o    = instret_q;

endmodule
